// File: rtl/half_adder_pkg.sv
// Shared types and defaults for the half-adder leaf cell.
// The lane result struct keeps sum/extra together through the datapath.
package half_adder_pkg;

    localparam int HA_DEFAULT_WIDTH = 1;

    typedef struct packed {
        logic sum;
        logic extra;
    } ha_lane_t;

    function automatic ha_lane_t ha_eval(input logic a, input logic b);
        ha_lane_t r;
        r.sum   = a ^ b;
        r.extra = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One combinational half-adder lane: XOR for sum, AND for carry-out.
module half_adder_lane
    import half_adder_pkg::*;
(
    input  logic     a,
    input  logic     b,
    output ha_lane_t res
);

    assign res = ha_eval(a, b);

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with an optional registered output stage
// and a sticky flag that records any carry-out on a qualified result.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = HA_DEFAULT_WIDTH,
    parameter bit REGISTERED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] bit1,
    input  logic [WIDTH-1:0] bit2,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] extra,
    output logic             valid_out,
    output logic             carry_seen
);

    ha_lane_t   [WIDTH-1:0] lane_res;
    logic       [WIDTH-1:0] sum_c;
    logic       [WIDTH-1:0] extra_c;

    // Qualified result feeding the sticky monitor, taken from whichever
    // stage drives the outputs.
    logic                   res_valid;
    logic                   res_carry;

    logic                   carry_seen_d;
    logic                   carry_seen_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            half_adder_lane u_lane (
                .a   (bit1[gi]),
                .b   (bit2[gi]),
                .res (lane_res[gi])
            );
            assign sum_c[gi]   = lane_res[gi].sum;
            assign extra_c[gi] = lane_res[gi].extra;
        end
    endgenerate

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] sum_d;
            logic [WIDTH-1:0] sum_q;
            logic [WIDTH-1:0] extra_d;
            logic [WIDTH-1:0] extra_q;
            logic             valid_d;
            logic             valid_q;

            always_comb begin
                sum_d   = sum_q;
                extra_d = extra_q;
                valid_d = en;
                if (en) begin
                    sum_d   = sum_c;
                    extra_d = extra_c;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q   <= '0;
                    extra_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    sum_q   <= sum_d;
                    extra_q <= extra_d;
                    valid_q <= valid_d;
                end
            end

            assign sum       = sum_q;
            assign extra     = extra_q;
            assign valid_out = valid_q;
            assign res_valid = valid_q;
            assign res_carry = |extra_q;
        end else begin : g_comb
            assign sum       = sum_c;
            assign extra     = extra_c;
            assign valid_out = en;
            assign res_valid = en;
            assign res_carry = |extra_c;
        end
    endgenerate

    // Clear takes priority over a coincident set.
    always_comb begin
        carry_seen_d = carry_seen_q;
        if (res_valid && res_carry) begin
            carry_seen_d = 1'b1;
        end
        if (clr) begin
            carry_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_seen_q <= 1'b0;
        end else begin
            carry_seen_q <= carry_seen_d;
        end
    end

    assign carry_seen = carry_seen_q;

endmodule

// File: tb/tb_half_adder.sv
// Directed checks of a combinational 1-lane instance and a registered 4-lane instance.
module tb_half_adder;

    logic clk;
    logic rst_n;

    // Combinational, WIDTH=1
    logic       en_c, clr_c, a_c, b_c;
    logic       sum_c, extra_c, valid_c, carry_c;

    // Registered, WIDTH=4
    logic       en_r, clr_r;
    logic [3:0] a_r, b_r, sum_r, extra_r;
    logic       valid_r, carry_r;

    int n_checks;
    int n_errors;

    half_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_comb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_c),
        .clr        (clr_c),
        .bit1       (a_c),
        .bit2       (b_c),
        .sum        (sum_c),
        .extra      (extra_c),
        .valid_out  (valid_c),
        .carry_seen (carry_c)
    );

    half_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_r),
        .clr        (clr_r),
        .bit1       (a_r),
        .bit2       (b_r),
        .sum        (sum_r),
        .extra      (extra_r),
        .valid_out  (valid_r),
        .carry_seen (carry_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: %b at %0t", tag, obs, $time);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    logic [1:0] vec_a [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] vec_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] vec_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] vec_x [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en_c = 1'b0; clr_c = 1'b0; a_c = 1'b0; b_c = 1'b0;
        en_r = 1'b0; clr_r = 1'b0; a_r = 4'h0; b_r = 4'h0;

        // Exhaustive combinational lane, run while reset is held to show independence.
        for (int i = 0; i < 4; i++) begin
            a_c = vec_a[i][0];
            b_c = vec_b[i][0];
            #50;
            check($sformatf("comb_sum_%0d", i),   {7'd0, sum_c},   {7'd0, vec_s[i][0]});
            check($sformatf("comb_extra_%0d", i), {7'd0, extra_c}, {7'd0, vec_x[i][0]});
            #50;
        end
        en_c = 1'b1;
        #1;
        check("comb_valid_follows_en", {7'd0, valid_c}, 8'd1);
        en_c = 1'b0;
        #1;
        check("comb_valid_follows_en0", {7'd0, valid_c}, 8'd0);

        // Registered instance under reset
        check("rst_sum",   {4'd0, sum_r},   8'h00);
        check("rst_extra", {4'd0, extra_r}, 8'h00);
        check("rst_valid", {7'd0, valid_r}, 8'd0);
        check("rst_carry", {7'd0, carry_r}, 8'd0);

        nedge();
        rst_n = 1'b1;

        // Combinational carry monitor: 0+0 valid, then 1+1 valid, then clr
        en_c = 1'b1; a_c = 1'b0; b_c = 1'b0;
        nedge();
        check("comb_carry_00", {7'd0, carry_c}, 8'd0);
        a_c = 1'b1; b_c = 1'b1;
        nedge();
        check("comb_carry_11", {7'd0, carry_c}, 8'd1);
        en_c = 1'b0; clr_c = 1'b1;
        nedge();
        check("comb_carry_clr", {7'd0, carry_c}, 8'd0);
        clr_c = 1'b0;

        // Registered 4-lane basic result
        en_r = 1'b1; a_r = 4'b1100; b_r = 4'b1010;
        nedge();
        check("reg_sum_1",   {4'd0, sum_r},   8'b0110);
        check("reg_extra_1", {4'd0, extra_r}, 8'b1000);
        check("reg_valid_1", {7'd0, valid_r}, 8'd1);
        check("reg_carry_lag", {7'd0, carry_r}, 8'd0);

        // en=0: outputs hold, valid drops, carry sets from prior valid result
        en_r = 1'b0; a_r = 4'b1111; b_r = 4'b1111;
        nedge();
        check("reg_sum_hold",   {4'd0, sum_r},   8'b0110);
        check("reg_extra_hold", {4'd0, extra_r}, 8'b1000);
        check("reg_valid_0",    {7'd0, valid_r}, 8'd0);
        check("reg_carry_set",  {7'd0, carry_r}, 8'd1);

        en_r = 1'b1; a_r = 4'b0001; b_r = 4'b0100;
        nedge();
        check("reg_sum_2",    {4'd0, sum_r},   8'b0101);
        check("reg_extra_2",  {4'd0, extra_r}, 8'b0000);
        check("reg_valid_2",  {7'd0, valid_r}, 8'd1);
        check("reg_carry_sticky", {7'd0, carry_r}, 8'd1);

        en_r = 1'b0; clr_r = 1'b1;
        nedge();
        check("reg_carry_clr", {7'd0, carry_r}, 8'd0);
        clr_r = 1'b0;

        // 0+0 valid leaves carry clear
        en_r = 1'b1; a_r = 4'b0000; b_r = 4'b0000;
        nedge();
        en_r = 1'b0;
        nedge();
        check("reg_carry_00", {7'd0, carry_r}, 8'd0);

        // clr coincident with a qualifying carry
        en_r = 1'b1; a_r = 4'b1000; b_r = 4'b1000;
        nedge();
        check("reg_extra_3", {4'd0, extra_r}, 8'b1000);
        en_r = 1'b0; clr_r = 1'b1;
        nedge();
        check("reg_carry_clr_wins", {7'd0, carry_r}, 8'd0);
        clr_r = 1'b0;
        nedge();
        check("reg_carry_after_clr", {7'd0, carry_r}, 8'd0);

        // Build valid_out=1 and carry_seen=1, then reset between edges
        en_r = 1'b1; a_r = 4'b1111; b_r = 4'b1111;
        nedge();
        nedge();
        check("pre_rst_valid", {7'd0, valid_r}, 8'd1);
        check("pre_rst_carry", {7'd0, carry_r}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum",   {4'd0, sum_r},   8'h00);
        check("async_rst_extra", {4'd0, extra_r}, 8'h00);
        check("async_rst_valid", {7'd0, valid_r}, 8'd0);
        check("async_rst_carry", {7'd0, carry_r}, 8'd0);
        nedge();
        check("rst_held_valid", {7'd0, valid_r}, 8'd0);
        a_r = 4'b0001; b_r = 4'b0001; en_r = 1'b1;
        rst_n = 1'b1;
        nedge();
        check("post_rst_sum",   {4'd0, sum_r},   8'b0000);
        check("post_rst_extra", {4'd0, extra_r}, 8'b0001);
        check("post_rst_valid", {7'd0, valid_r}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
